// File: rtl/datamover_sts_tracker.sv
// DataMover status tracker: 2-entry skid buffer on the status stream plus per-stream counters and a coalesced irq.
// Optional DATAMOVER_STS_TRACKER_ERR_IRQ_EN: a bad status beat raises its stream's pending bit at once.
module datamover_sts_tracker #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH      = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH      = 32,
    parameter int unsigned C_M_AXIS_STS_DATA_WIDTH = 8,
    parameter int unsigned C_STREAMS_WIDTH         = 2,
    parameter int unsigned C_PAGEWIDTH             = 16,
    parameter int unsigned C_REG_BASE              = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               S_AXIS_STS_TVALID,
    output logic                               S_AXIS_STS_TREADY,
    input  logic [C_M_AXIS_STS_DATA_WIDTH-1:0] S_AXIS_STS_TDATA,
    output logic                               M_AXIS_STS_TVALID,
    input  logic                               M_AXIS_STS_TREADY,
    output logic [C_M_AXIS_STS_DATA_WIDTH-1:0] M_AXIS_STS_TDATA,
    input  logic                               cmd_fire,
    input  logic [3:0]                         cmd_tag,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      set_data,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      set_addr,
    input  logic                               set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      get_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      get_data,
    output logic                               irq
);

    localparam int unsigned DW = C_M_AXIS_STS_DATA_WIDTH;
    localparam int unsigned RW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_STREAMS_WIDTH;
    localparam int unsigned NS = 1 << C_STREAMS_WIDTH;
    localparam int unsigned AW = C_PAGEWIDTH - 2;

    // ---------------- skid buffer ----------------
    logic [1:0]    r_cnt;
    logic [DW-1:0] r_buf0;
    logic [DW-1:0] r_buf1;
    logic          r_s_ready;
    logic          r_m_valid;
    logic [1:0]    w_cnt_nxt;
    logic [DW-1:0] w_buf0_nxt;
    logic [DW-1:0] w_buf1_nxt;
    logic          w_s_fire;
    logic          w_m_fire;

    assign w_s_fire          = S_AXIS_STS_TVALID && r_s_ready;
    assign w_m_fire          = r_m_valid && M_AXIS_STS_TREADY;
    assign S_AXIS_STS_TREADY = r_s_ready;
    assign M_AXIS_STS_TVALID = r_m_valid;
    assign M_AXIS_STS_TDATA  = r_buf0;

    // r_buf0 is always the head; r_buf1 only holds the second beat when full
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        case (r_cnt)
            2'd0: begin
                if (w_s_fire) begin
                    w_buf0_nxt = S_AXIS_STS_TDATA;
                    w_cnt_nxt  = 2'd1;
                end
            end
            2'd1: begin
                if (w_s_fire && w_m_fire) begin
                    w_buf0_nxt = S_AXIS_STS_TDATA;
                end else if (w_s_fire) begin
                    w_buf1_nxt = S_AXIS_STS_TDATA;
                    w_cnt_nxt  = 2'd2;
                end else if (w_m_fire) begin
                    w_cnt_nxt = 2'd0;
                end
            end
            default: begin
                if (w_m_fire) begin
                    w_buf0_nxt = r_buf1;
                    w_cnt_nxt  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_buf0    <= w_buf0_nxt;
            r_buf1    <= w_buf1_nxt;
            r_s_ready <= (w_cnt_nxt != 2'd2);
            r_m_valid <= (w_cnt_nxt != 2'd0);
        end
    end

    // ---------------- register decode ----------------
    logic [AW-1:0] w_set_word;
    logic [AW-1:0] w_get_word;
    logic [SW-1:0] w_set_strm;
    logic [SW-1:0] w_get_strm;
    logic [1:0]    w_set_reg;
    logic [1:0]    w_get_reg;
    logic          w_wr_strm;
    logic          w_wr_stat;
    logic          w_wr_en;
    logic          w_get_inwin;
    logic [SW-1:0] w_s_strm;
    logic [SW-1:0] w_cmd_strm;
    logic          w_bad;

    assign w_set_word  = set_addr[C_PAGEWIDTH-1:2] - AW'(C_REG_BASE);
    assign w_get_word  = get_addr[C_PAGEWIDTH-1:2] - AW'(C_REG_BASE);
    assign w_set_strm  = w_set_word[SW+1:2];
    assign w_get_strm  = w_get_word[SW+1:2];
    assign w_set_reg   = w_set_word[1:0];
    assign w_get_reg   = w_get_word[1:0];
    assign w_wr_strm   = set_stb && (w_set_word < AW'(4 * NS));
    assign w_wr_stat   = set_stb && (w_set_word == AW'(4 * NS));
    assign w_wr_en     = set_stb && (w_set_word == AW'(4 * NS + 1));
    assign w_get_inwin = (w_get_word < AW'(4 * NS));
    assign w_s_strm    = S_AXIS_STS_TDATA[SW-1:0];
    assign w_cmd_strm  = cmd_tag[SW-1:0];
    assign w_bad       = !S_AXIS_STS_TDATA[7] || (|S_AXIS_STS_TDATA[6:4]);

    // ---------------- counters ----------------
    logic [NS-1:0][31:0] r_compl,    w_compl_nxt;
    logic [NS-1:0][15:0] r_err_cnt,  w_err_cnt_nxt;
    logic [NS-1:0][7:0]  r_last_bad, w_last_bad_nxt;
    logic [NS-1:0][7:0]  r_outst,    w_outst_nxt;
    logic [NS-1:0]       r_uf,       w_uf_nxt;
    logic [NS-1:0][7:0]  r_thresh,   w_thresh_nxt;
    logic [NS-1:0][7:0]  r_coal,     w_coal_nxt;
    logic [NS-1:0]       r_pending,  w_pending_nxt;
    logic [NS-1:0]       r_irq_en,   w_irq_en_nxt;
    logic                r_irq;

    // register-bus clears are applied first, then the stream events of the same cycle
    always_comb begin
        w_compl_nxt    = r_compl;
        w_err_cnt_nxt  = r_err_cnt;
        w_last_bad_nxt = r_last_bad;
        w_outst_nxt    = r_outst;
        w_uf_nxt       = r_uf;
        w_thresh_nxt   = r_thresh;
        w_coal_nxt     = r_coal;
        w_pending_nxt  = r_pending;
        w_irq_en_nxt   = r_irq_en;
        if (w_wr_stat) begin
            w_pending_nxt = r_pending & ~set_data[NS-1:0];
        end
        if (w_wr_en) begin
            w_irq_en_nxt = set_data[NS-1:0];
        end
        for (int unsigned m = 0; m < NS; m++) begin
            if (w_wr_strm && (w_set_strm == SW'(m))) begin
                case (w_set_reg)
                    2'd0: w_compl_nxt[SW'(m)] = '0;
                    2'd1: begin
                        w_err_cnt_nxt[SW'(m)]  = '0;
                        w_last_bad_nxt[SW'(m)] = '0;
                    end
                    2'd2: w_uf_nxt[SW'(m)] = 1'b0;
                    default: begin
                        w_thresh_nxt[SW'(m)] = set_data[7:0];
                        w_coal_nxt[SW'(m)]   = '0;
                    end
                endcase
            end
            if (w_s_fire && (w_s_strm == SW'(m))) begin
                w_compl_nxt[SW'(m)] = w_compl_nxt[SW'(m)] + 32'd1;
                if (w_bad) begin
                    if (w_err_cnt_nxt[SW'(m)] != 16'hFFFF) begin
                        w_err_cnt_nxt[SW'(m)] = w_err_cnt_nxt[SW'(m)] + 16'd1;
                    end
                    w_last_bad_nxt[SW'(m)] = S_AXIS_STS_TDATA[7:0];
`ifdef DATAMOVER_STS_TRACKER_ERR_IRQ_EN
                    w_pending_nxt[SW'(m)] = 1'b1;
`else
                    w_pending_nxt[SW'(m)] = w_pending_nxt[SW'(m)];
`endif
                end
                w_coal_nxt[SW'(m)] = w_coal_nxt[SW'(m)] + 8'd1;
                if ((w_thresh_nxt[SW'(m)] != 8'd0) && (w_coal_nxt[SW'(m)] == w_thresh_nxt[SW'(m)])) begin
                    w_pending_nxt[SW'(m)] = 1'b1;
                    w_coal_nxt[SW'(m)]    = '0;
                end
            end
            // simultaneous command and status on one stream cancel out
            if (cmd_fire && (w_cmd_strm == SW'(m)) && !(w_s_fire && (w_s_strm == SW'(m)))) begin
                if (r_outst[SW'(m)] != 8'hFF) begin
                    w_outst_nxt[SW'(m)] = r_outst[SW'(m)] + 8'd1;
                end
            end else if (w_s_fire && (w_s_strm == SW'(m)) && !(cmd_fire && (w_cmd_strm == SW'(m)))) begin
                if (r_outst[SW'(m)] == 8'd0) begin
                    w_uf_nxt[SW'(m)] = 1'b1;
                end else begin
                    w_outst_nxt[SW'(m)] = r_outst[SW'(m)] - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_compl    <= '0;
            r_err_cnt  <= '0;
            r_last_bad <= '0;
            r_outst    <= '0;
            r_uf       <= '0;
            r_thresh   <= '0;
            r_coal     <= '0;
            r_pending  <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_compl    <= w_compl_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_last_bad <= w_last_bad_nxt;
            r_outst    <= w_outst_nxt;
            r_uf       <= w_uf_nxt;
            r_thresh   <= w_thresh_nxt;
            r_coal     <= w_coal_nxt;
            r_pending  <= w_pending_nxt;
            r_irq_en   <= w_irq_en_nxt;
            r_irq      <= |(w_pending_nxt & w_irq_en_nxt);
        end
    end

    assign irq = r_irq;

    // ---------------- read mux ----------------
    logic [RW-1:0] w_rd;

    always_comb begin
        w_rd = '0;
        if (w_get_inwin) begin
            case (w_get_reg)
                2'd0:    w_rd = RW'(r_compl[w_get_strm]);
                2'd1:    w_rd = RW'({8'h00, r_last_bad[w_get_strm], r_err_cnt[w_get_strm]});
                2'd2:    w_rd = RW'({23'd0, r_uf[w_get_strm], r_outst[w_get_strm]});
                default: w_rd = RW'(r_thresh[w_get_strm]);
            endcase
        end else if (w_get_word == AW'(4 * NS)) begin
            w_rd = RW'(r_pending);
        end else if (w_get_word == AW'(4 * NS + 1)) begin
            w_rd = RW'(r_irq_en);
        end
    end

    assign get_data = w_rd;

    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, set_addr, get_addr, set_data, cmd_tag};

endmodule

// File: tb/tb_datamover_sts_tracker.sv
// Scoreboard bench for datamover_sts_tracker: expected beats and register values are queued, a monitor compares.
module tb_datamover_sts_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        S_AXIS_STS_TVALID;
    logic        S_AXIS_STS_TREADY;
    logic [7:0]  S_AXIS_STS_TDATA;
    logic        M_AXIS_STS_TVALID;
    logic        M_AXIS_STS_TREADY;
    logic [7:0]  M_AXIS_STS_TDATA;
    logic        cmd_fire;
    logic [3:0]  cmd_tag;
    logic [31:0] set_data;
    logic [31:0] set_addr;
    logic        set_stb;
    logic [31:0] get_addr;
    logic [31:0] get_data;
    logic        irq;

    always #5 clk = ~clk;

    datamover_sts_tracker dut (
        .clk               (clk),
        .rst               (rst),
        .S_AXIS_STS_TVALID (S_AXIS_STS_TVALID),
        .S_AXIS_STS_TREADY (S_AXIS_STS_TREADY),
        .S_AXIS_STS_TDATA  (S_AXIS_STS_TDATA),
        .M_AXIS_STS_TVALID (M_AXIS_STS_TVALID),
        .M_AXIS_STS_TREADY (M_AXIS_STS_TREADY),
        .M_AXIS_STS_TDATA  (M_AXIS_STS_TDATA),
        .cmd_fire          (cmd_fire),
        .cmd_tag           (cmd_tag),
        .set_data          (set_data),
        .set_addr          (set_addr),
        .set_stb           (set_stb),
        .get_addr          (get_addr),
        .get_data          (get_data),
        .irq               (irq)
    );

    // kind: 0 get_data, 1 irq, 2 S_TREADY, 3 M_TVALID, 4 M_TDATA, 5 bench-computed value in act
    typedef struct {
        int          kind;
        logic [31:0] exp;
        logic [31:0] act;
        string       name;
    } chk_t;

    chk_t        chk_q[$];
    logic [7:0]  beat_q[$];
    logic        chk_req = 1'b0;
    int          checks = 0;
    int          errors = 0;
    chk_t        mon_c;
    logic [31:0] mon_act;
    logic [7:0]  mon_beat;

`ifdef DATAMOVER_STS_TRACKER_ERR_IRQ_EN
    localparam logic [31:0] EXP_PEND_ERR = 32'h4;
`else
    localparam logic [31:0] EXP_PEND_ERR = 32'h0;
`endif

    // monitor: pops the scoreboard on every M handshake and on every requested register check
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (M_AXIS_STS_TVALID && M_AXIS_STS_TREADY) begin
                    checks++;
                    if (beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got %h, required no beat", M_AXIS_STS_TDATA);
                    end else begin
                        mon_beat = beat_q.pop_front();
                        if (M_AXIS_STS_TDATA !== mon_beat) begin
                            errors++;
                            $display("FAIL beat_order: got %h, required %h", M_AXIS_STS_TDATA, mon_beat);
                        end
                    end
                end else if (M_AXIS_STS_TVALID && beat_q.size() != 0) begin
                    checks++;
                    if (M_AXIS_STS_TDATA !== beat_q[0]) begin
                        errors++;
                        $display("FAIL beat_stall: got %h, required %h", M_AXIS_STS_TDATA, beat_q[0]);
                    end
                end
                if (chk_req && chk_q.size() != 0) begin
                    mon_c = chk_q.pop_front();
                    case (mon_c.kind)
                        0:       mon_act = get_data;
                        1:       mon_act = 32'(irq);
                        2:       mon_act = 32'(S_AXIS_STS_TREADY);
                        3:       mon_act = 32'(M_AXIS_STS_TVALID);
                        4:       mon_act = 32'(M_AXIS_STS_TDATA);
                        default: mon_act = mon_c.act;
                    endcase
                    checks++;
                    if (mon_act !== mon_c.exp) begin
                        errors++;
                        $display("FAIL %s: got %h, required %h", mon_c.name, mon_act, mon_c.exp);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] waddr(input int w);
        return 32'((32 + w) * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int kind, input logic [31:0] exp, input string name, input logic [31:0] act);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.act  = act;
        c.name = name;
        chk_q.push_back(c);
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
        tick();
    endtask

    task automatic rd(input int w, input logic [31:0] exp, input string name);
        get_addr = waddr(w);
        check(0, exp, name, 32'h0);
    endtask

    task automatic wr(input int w, input logic [31:0] d);
        set_addr = waddr(w);
        set_data = d;
        set_stb  = 1'b1;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        S_AXIS_STS_TVALID = 1'b1;
        S_AXIS_STS_TDATA  = d;
        while (!S_AXIS_STS_TREADY && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXIS_STS_TREADY) begin
            S_AXIS_STS_TVALID = 1'b0;
            check(5, 32'h1, "s_ready_timeout", 32'h0);
        end else begin
            beat_q.push_back(d);
            tick();
            S_AXIS_STS_TVALID = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        S_AXIS_STS_TVALID = 1'b0;
        S_AXIS_STS_TDATA  = 8'h00;
        M_AXIS_STS_TREADY = 1'b1;
        cmd_fire          = 1'b0;
        cmd_tag           = 4'h0;
        set_data          = 32'h0;
        set_addr          = 32'h0;
        set_stb           = 1'b0;
        get_addr          = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check(2, 32'h1, "rst_s_tready", 32'h0);
        check(3, 32'h0, "rst_m_tvalid", 32'h0);
        check(4, 32'h0, "rst_m_tdata", 32'h0);
        check(1, 32'h0, "rst_irq", 32'h0);
        rd(0, 32'h0, "rst_compl0");
        rd(19, 32'h0, "unmapped");

        // four OK beats, one per stream, back to back
        send(8'h80);
        send(8'h81);
        send(8'h82);
        send(8'h83);
        tick();
        check(5, 32'h0, "pass_latency", 32'(beat_q.size()));
        rd(0, 32'h1, "compl0");
        rd(4, 32'h1, "compl1");
        rd(8, 32'h1, "compl2");
        rd(12, 32'h1, "compl3");
        rd(1, 32'h0, "err0_ok");
        check(1, 32'h0, "irq_after_ok", 32'h0);

        // coalescing on stream 1
        wr(7, 32'h3);
        wr(17, 32'h2);
        rd(7, 32'h3, "thresh1");
        rd(17, 32'h2, "irq_en");
        send(8'h81);
        send(8'h81);
        check(1, 32'h0, "irq_before_thresh", 32'h0);
        send(8'h81);
        check(1, 32'h1, "irq_at_thresh", 32'h0);
        rd(16, 32'h2, "irq_stat");
        wr(16, 32'h2);
        check(1, 32'h0, "irq_w1c", 32'h0);
        send(8'h81);
        send(8'h81);
        send(8'h81);
        check(1, 32'h1, "irq_coal_restart", 32'h0);
        rd(4, 32'h7, "compl1_after");
        wr(16, 32'h2);

        // backpressure: two accepted, third held off
        M_AXIS_STS_TREADY = 1'b0;
        send(8'h83);
        send(8'h87);
        S_AXIS_STS_TVALID = 1'b1;
        S_AXIS_STS_TDATA  = 8'h8B;
        check(2, 32'h0, "skid_full", 32'h0);
        check(3, 32'h1, "skid_mvalid", 32'h0);
        check(4, 32'h83, "skid_head", 32'h0);
        M_AXIS_STS_TREADY = 1'b1;
        send(8'h8B);
        tick();
        tick();
        check(5, 32'h0, "skid_drained", 32'(beat_q.size()));
        rd(12, 32'h4, "compl3");

        // outstanding count and error decode on stream 2
        wr(10, 32'h0);
        rd(10, 32'h0, "outst2_clr");
        cmd_fire = 1'b1;
        cmd_tag  = 4'h2;
        tick();
        tick();
        cmd_fire = 1'b0;
        rd(10, 32'h2, "outst2_two");
        send(8'h22);
        tick();
        rd(10, 32'h1, "outst2_one");
        rd(9, 32'h0022_0001, "err2");
        rd(16, EXP_PEND_ERR, "pend_err");
        check(1, 32'h0, "irq_err_masked", 32'h0);
        wr(9, 32'h0);
        rd(9, 32'h0, "err2_clr");

        // underflow on stream 0 and simultaneous inc/dec
        wr(2, 32'h0);
        rd(2, 32'h0, "outst0_clr");
        send(8'h80);
        rd(2, 32'h100, "outst0_underflow");
        wr(2, 32'h0);
        rd(2, 32'h0, "outst0_uf_clr");
        cmd_fire = 1'b1;
        cmd_tag  = 4'h0;
        tick();
        cmd_fire = 1'b0;
        rd(2, 32'h1, "outst0_inc");
        cmd_fire = 1'b1;
        send(8'h80);
        cmd_fire = 1'b0;
        rd(2, 32'h1, "outst0_inc_dec");

        // clear write coinciding with an accept leaves 1
        set_addr = waddr(0);
        set_data = 32'h0;
        set_stb  = 1'b1;
        send(8'h80);
        set_stb  = 1'b0;
        rd(0, 32'h1, "compl0_clr_evt");

        // outstanding saturation on stream 3
        cmd_fire = 1'b1;
        cmd_tag  = 4'h3;
        repeat (300) tick();
        cmd_fire = 1'b0;
        rd(14, 32'h1FF, "outst3_sat");

        repeat (3) tick();
        check(5, 32'h0, "beats_all_out", 32'(beat_q.size()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
